// File: rtl/md_issue_ctrl.sv
// Issue/scoreboard controller for the shared iterative multiply/divide unit.
// Optional macro MDU_FORWARD_EN: bypass the MDU result into ID during the writeback-accept cycle.
module md_issue_ctrl #(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 33,
  parameter int CNT_W   = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       md_req_ID,
  input  logic       md_is_div_ID,
  input  logic [4:0] rd_ID,
  input  logic       rduse_ID,
  input  logic [4:0] rs1_ID,
  input  logic [4:0] rs2_ID,
  input  logic       rs1use_ID,
  input  logic       rs2use_ID,
  input  logic       flush_ID,
  input  logic       wb_port_free,
  output logic       md_start,
  output logic       md_busy,
  output logic [4:0] md_rd,
  output logic       md_wb_valid,
  output logic       stall_ID,
  output logic       fwd_md_ID
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    WB   = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       md_rd_q, md_rd_d;
  logic             busy_q, busy_d;
  logic             wb_valid_q, wb_valid_d;

  logic rd_live, raw_hit, waw_hit, struct_hit, wb_accept;
  logic raw_stall, fwd_ok, issue;

  // Hazard detection against the single in-flight op.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    fwd_ok     = 1'b0;
    raw_stall  = 1'b0;
    rd_live    = busy_q && (md_rd_q != 5'd0);
    raw_hit    = rd_live && ((rs1use_ID && (rs1_ID == md_rd_q)) ||
                             (rs2use_ID && (rs2_ID == md_rd_q)));
    waw_hit    = rd_live && rduse_ID && (rd_ID == md_rd_q);
    wb_accept  = (state_q == WB) && wb_port_free;
    struct_hit = md_req_ID && ((state_q == BUSY) || ((state_q == WB) && !wb_port_free));
`ifdef MDU_FORWARD_EN
    fwd_ok    = wb_accept && raw_hit;
    raw_stall = raw_hit && !wb_accept;
`else
    fwd_ok    = 1'b0;
    raw_stall = raw_hit;
`endif
    stall_ID  = !rst && !flush_ID && (struct_hit || waw_hit || raw_stall);
    issue     = !rst && md_req_ID && !flush_ID && !stall_ID &&
                ((state_q == IDLE) || wb_accept);
    md_start  = issue;
    fwd_md_ID = !rst && fwd_ok;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    md_rd_d = md_rd_q;
    unique case (state_q)
      IDLE: ;
      BUSY: begin
        if (cnt_q == CNT_W'(1)) state_d = WB;
        cnt_d = cnt_q - CNT_W'(1);
      end
      WB:      if (wb_port_free) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A new op may start from IDLE or in the same cycle the previous result is accepted.
    if (issue) begin
      state_d = BUSY;
      cnt_d   = md_is_div_ID ? DIV_LOAD : MUL_LOAD;
      md_rd_d = rd_ID;
    end
    busy_d     = (state_d != IDLE);
    wb_valid_d = (state_d == WB);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      md_rd_q    <= '0;
      busy_q     <= 1'b0;
      wb_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      md_rd_q    <= md_rd_d;
      busy_q     <= busy_d;
      wb_valid_q <= wb_valid_d;
    end
  end

  assign md_busy     = busy_q;
  assign md_rd       = md_rd_q;
  assign md_wb_valid = wb_valid_q;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed self-checking bench for md_issue_ctrl (MUL_LAT=3, DIV_LAT=33).
// Cycle cN is the window after rising edge N; inputs change at +1, outputs sampled at +2.
module tb_md_issue_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       md_req_ID, md_is_div_ID, rduse_ID, rs1use_ID, rs2use_ID, flush_ID, wb_port_free;
  logic [4:0] rd_ID, rs1_ID, rs2_ID;
  logic       md_start, md_busy, md_wb_valid, stall_ID, fwd_md_ID;
  logic [4:0] md_rd;

  int checks   = 0;
  int failures = 0;

  md_issue_ctrl #(.MUL_LAT(3), .DIV_LAT(33), .CNT_W(6)) dut (
    .clk(clk), .rst(rst),
    .md_req_ID(md_req_ID), .md_is_div_ID(md_is_div_ID), .rd_ID(rd_ID), .rduse_ID(rduse_ID),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rs1use_ID(rs1use_ID), .rs2use_ID(rs2use_ID),
    .flush_ID(flush_ID), .wb_port_free(wb_port_free),
    .md_start(md_start), .md_busy(md_busy), .md_rd(md_rd), .md_wb_valid(md_wb_valid),
    .stall_ID(stall_ID), .fwd_md_ID(fwd_md_ID)
  );

  always #5 clk = ~clk;

  // Observed control vector: {md_start, md_busy, md_wb_valid, stall_ID, fwd_md_ID}
  logic [4:0] ctl;
  assign ctl = {md_start, md_busy, md_wb_valid, stall_ID, fwd_md_ID};

`ifdef MDU_FORWARD_EN
  localparam logic [4:0] RAW_WB_CTL = 5'b01101;
`else
  localparam logic [4:0] RAW_WB_CTL = 5'b01110;
`endif

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    md_req_ID = 0; md_is_div_ID = 0; rd_ID = 0; rduse_ID = 0;
    rs1_ID = 0; rs2_ID = 0; rs1use_ID = 0; rs2use_ID = 0;
    flush_ID = 0; wb_port_free = 1;
  endtask

  task automatic issue_op(input logic is_div, input logic [4:0] rd);
    clear_inputs();
    md_req_ID = 1; md_is_div_ID = is_div; rd_ID = rd; rduse_ID = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    repeat (3) next_cycle();
    rst = 0;
    next_cycle(); #1;
    checks++; if (ctl !== 5'b00000) begin failures++; $display("FAIL reset_ctl got=%b exp=%b", ctl, 5'b00000); end
    checks++; if (md_rd !== 5'd0) begin failures++; $display("FAIL reset_md_rd got=%0d exp=0", md_rd); end
  endtask

  // MUL rd=5 at c0, dependent ADD rs1=5 waits in ID from c1.
  task automatic test_mul_raw();
    next_cycle(); issue_op(0, 5'd5); #1;
    checks++; if (ctl !== 5'b10000) begin failures++; $display("FAIL mul_c0 got=%b exp=%b", ctl, 5'b10000); end
    for (int c = 1; c <= 2; c++) begin
      next_cycle(); clear_inputs(); rs1_ID = 5; rs1use_ID = 1; #1;
      checks++; if (ctl !== 5'b01010) begin failures++; $display("FAIL mul_busy_c%0d got=%b exp=%b", c, ctl, 5'b01010); end
      checks++; if (md_rd !== 5'd5) begin failures++; $display("FAIL mul_rd_c%0d got=%0d exp=5", c, md_rd); end
    end
    next_cycle(); #1;
    checks++; if (ctl !== RAW_WB_CTL) begin failures++; $display("FAIL mul_wb_c3 got=%b exp=%b", ctl, RAW_WB_CTL); end
    next_cycle(); #1;
    checks++; if (ctl !== 5'b00000) begin failures++; $display("FAIL mul_idle_c4 got=%b exp=%b", ctl, 5'b00000); end
    clear_inputs();
  endtask

  // DIV rd=7 at c0, MUL rd=8 waits; MUL issues in the DIV accept cycle.
  task automatic test_back_to_back();
    next_cycle(); issue_op(1, 5'd7); #1;
    checks++; if (md_start !== 1'b1) begin failures++; $display("FAIL div_start got=%b exp=1", md_start); end
    for (int c = 1; c <= 32; c++) begin
      next_cycle(); issue_op(0, 5'd8); #1;
      if (c == 1 || c == 16 || c == 32) begin
        checks++; if (ctl !== 5'b01010) begin failures++; $display("FAIL div_wait_c%0d got=%b exp=%b", c, ctl, 5'b01010); end
      end
    end
    next_cycle(); issue_op(0, 5'd8); #1;
    checks++; if (ctl !== 5'b11100) begin failures++; $display("FAIL b2b_c33 got=%b exp=%b", ctl, 5'b11100); end
    checks++; if (md_rd !== 5'd7) begin failures++; $display("FAIL b2b_rd_c33 got=%0d exp=7", md_rd); end
    next_cycle(); clear_inputs(); #1;
    checks++; if (ctl !== 5'b01000) begin failures++; $display("FAIL b2b_c34 got=%b exp=%b", ctl, 5'b01000); end
    checks++; if (md_rd !== 5'd8) begin failures++; $display("FAIL b2b_rd_c34 got=%0d exp=8", md_rd); end
    next_cycle(); next_cycle(); #1;
    checks++; if (ctl !== 5'b01100) begin failures++; $display("FAIL b2b_mul_wb_c36 got=%b exp=%b", ctl, 5'b01100); end
    next_cycle(); #1;
    checks++; if (md_busy !== 1'b0) begin failures++; $display("FAIL b2b_idle_c37 got=%b exp=0", md_busy); end
  endtask

  // Writeback slot busy c3-c4; a new MDU request at c4 is a structural stall.
  task automatic test_wb_backpressure();
    next_cycle(); issue_op(0, 5'd5); #1;
    next_cycle(); clear_inputs();
    next_cycle();
    next_cycle(); wb_port_free = 0; #1;
    checks++; if (ctl !== 5'b01100 || md_rd !== 5'd5) begin failures++; $display("FAIL bp_c3 got=%b/%0d exp=%b/5", ctl, md_rd, 5'b01100); end
    next_cycle(); issue_op(0, 5'd9); wb_port_free = 0; #1;
    checks++; if (ctl !== 5'b01110 || md_rd !== 5'd5) begin failures++; $display("FAIL bp_c4 got=%b/%0d exp=%b/5", ctl, md_rd, 5'b01110); end
    next_cycle(); clear_inputs(); #1;
    checks++; if (ctl !== 5'b01100 || md_rd !== 5'd5) begin failures++; $display("FAIL bp_c5 got=%b/%0d exp=%b/5", ctl, md_rd, 5'b01100); end
    next_cycle(); #1;
    checks++; if (ctl !== 5'b00000) begin failures++; $display("FAIL bp_idle_c6 got=%b exp=%b", ctl, 5'b00000); end
  endtask

  // rd=0 never creates RAW/WAW hazards; flush blocks issue and forces stall low.
  task automatic test_rd_zero_flush();
    next_cycle(); issue_op(0, 5'd0); #1;
    for (int c = 1; c <= 3; c++) begin
      next_cycle(); clear_inputs();
      rs1_ID = 0; rs2_ID = 0; rs1use_ID = 1; rs2use_ID = 1; rd_ID = 0; rduse_ID = 1; #1;
      checks++; if (stall_ID !== 1'b0) begin failures++; $display("FAIL rd0_stall_c%0d got=%b exp=0", c, stall_ID); end
    end
    checks++; if (md_wb_valid !== 1'b1) begin failures++; $display("FAIL rd0_wb_c3 got=%b exp=1", md_wb_valid); end
    next_cycle(); issue_op(0, 5'd6); flush_ID = 1; #1;
    checks++; if (ctl !== 5'b00000) begin failures++; $display("FAIL flush_issue got=%b exp=%b", ctl, 5'b00000); end
    next_cycle(); clear_inputs(); #1;
    checks++; if (md_busy !== 1'b0) begin failures++; $display("FAIL flush_no_op got=%b exp=0", md_busy); end
    issue_op(0, 5'd5); #1;
    next_cycle(); clear_inputs(); rs1_ID = 5; rs1use_ID = 1; flush_ID = 1; #1;
    checks++; if (ctl !== 5'b01000) begin failures++; $display("FAIL flush_raw got=%b exp=%b", ctl, 5'b01000); end
    next_cycle(); clear_inputs();
    next_cycle();
    next_cycle(); #1;
    checks++; if (md_busy !== 1'b0) begin failures++; $display("FAIL flush_drain got=%b exp=0", md_busy); end
  endtask

  // Reset in the middle of a DIV; a RAW candidate in ID must not stall afterwards.
  task automatic test_reset_mid_op();
    next_cycle(); issue_op(1, 5'd7); #1;
    next_cycle(); clear_inputs();
    next_cycle(); rst = 1; issue_op(0, 5'd3); #1;
    checks++; if (md_start !== 1'b0) begin failures++; $display("FAIL rst_start_gate got=%b exp=0", md_start); end
    next_cycle(); rst = 0; clear_inputs(); rs1_ID = 7; rs1use_ID = 1; #1;
    checks++; if (ctl !== 5'b00000 || md_rd !== 5'd0) begin failures++; $display("FAIL rst_mid_c3 got=%b/%0d exp=%b/0", ctl, md_rd, 5'b00000); end
    clear_inputs();
  endtask

  initial begin
    fork
      begin
        test_reset();
        test_mul_raw();
        test_back_to_back();
        test_wb_backpressure();
        test_rd_zero_flush();
        test_reset_mid_op();
      end
      begin
        #20000;
        failures++;
        $display("FAIL timeout got=running exp=done");
      end
    join_any
    disable fork;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
